rsa_byte_framer: RTL and testbench

- Byte-stream front/back end for the 128-bit RSA exponentiation engine `top_level_enc` (ports start/message/e_key/n/c/done).
- Assembles 16 input bytes, MSB first, into one message block and checks that the block is less than the modulus n.
- Launches the engine, captures the result c on a done rising edge, and serializes c back out as 16 bytes, MSB first.
- Sits directly upstream and downstream of the engine; e_key and n are wired straight to the engine by the parent.

---
 rtl/rsa_byte_framer.sv | 165 ++++++++++++++++
 tb/tb_rsa_byte_framer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_byte_framer.sv
// rsa_byte_framer: byte-stream wrapper around the 128-bit RSA engine.
// Gathers NBYTES input bytes (MSB first) into one block, rejects blocks that
// are not below the modulus, launches the engine, and streams the result back
// out MSB first. Only one block is in flight at a time; input is refused while
// a block is being checked, computed or emitted.
module rsa_byte_framer #(
  parameter int          WIDTH   = 128,
  parameter int          NBYTES  = WIDTH / 8,
  parameter logic [23:0] TIMEOUT = 24'd16777215
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  output logic             enc_start,
  output logic [WIDTH-1:0] enc_message,
  input  logic             enc_done,
  input  logic [WIDTH-1:0] enc_c,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             range_err,
  output logic             timeout_err,
  output logic             busy
);

  // Byte counter is shared by COLLECT and EMIT; it only needs to reach NBYTES-1.
  localparam int              CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [23:0]      TMO_LAST  = TIMEOUT - 24'd1;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_START,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [23:0]        tmo_cnt_q,  tmo_cnt_d;
  logic               done_q;
  logic [WIDTH-1:0]   msg_q,      msg_d;
  logic [WIDTH-1:0]   res_q,      res_d;
  logic [WIDTH-1:0]   enc_msg_q,  enc_msg_d;
  logic               done_rise;

  // A done level that was already high before this cycle is not a completion.
  assign done_rise   = enc_done & ~done_q;

  assign enc_message = enc_msg_q;
  assign out_data    = res_q[WIDTH-1 -: 8];

  // Control state: FSM, byte/timeout counters and the done edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_COLLECT;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      done_q     <= enc_done;
    end
  end

  // Block-wide registers: input assembly, engine operand and result shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q     <= '0;
      res_q     <= '0;
      enc_msg_q <= '0;
    end else begin
      msg_q     <= msg_d;
      res_q     <= res_d;
      enc_msg_q <= enc_msg_d;
    end
  end

  // Next-state and output decode for the framer FSM.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    msg_d       = msg_q;
    res_d       = res_q;
    enc_msg_d   = enc_msg_q;
    in_ready    = 1'b0;
    enc_start   = 1'b0;
    out_valid   = 1'b0;
    range_err   = 1'b0;
    timeout_err = 1'b0;
    busy        = 1'b1;

    unique case (state_q)
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          // Shift form keeps this legal for a single-byte block as well.
          msg_d = (msg_q << 8) | WIDTH'(in_data);
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_CHECK;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end

      S_CHECK: begin
        // Unsigned compare; n == 0 can never be satisfied and so is rejected.
        if (msg_q < n) begin
          enc_msg_d = msg_q;
          state_d   = S_START;
        end else begin
          range_err = 1'b1;
          state_d   = S_COLLECT;
        end
      end

      S_START: begin
        enc_start = 1'b1;
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // A completion seen on the last allowed cycle still wins over timeout.
        if (done_rise) begin
          res_d   = enc_c;
          state_d = S_EMIT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_err = 1'b1;
          state_d     = S_COLLECT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          res_d = res_q << 8;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_COLLECT;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_byte_framer.sv
// Testbench for rsa_byte_framer: table of blocks with hand-computed engine
// results, plus reset-state and mid-operation reset sequences.
module tb_rsa_byte_framer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] n;
  logic         enc_start;
  logic [127:0] enc_message;
  logic         enc_done = 1'b0;
  logic [127:0] enc_c = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         range_err;
  logic         timeout_err;
  logic         busy;

  always #5 clk = ~clk;

  rsa_byte_framer #(
    .WIDTH  (128),
    .NBYTES (16),
    .TIMEOUT(24'd20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n          (n),
    .enc_start  (enc_start),
    .enc_message(enc_message),
    .enc_done   (enc_done),
    .enc_c      (enc_c),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .range_err  (range_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  // Engine stub: result = message ^ A5..A5, done rises 10 cycles after start
  // and stays high until the next start. In stale mode done is simply held high.
  logic stub_stale = 1'b0;
  logic stub_pend  = 1'b0;
  int   stub_cnt   = 0;
  always @(negedge clk) begin
    if (stub_stale) begin
      enc_done = 1'b1;
    end else if (enc_start) begin
      enc_done  = 1'b0;
      stub_cnt  = 10;
      stub_pend = 1'b1;
    end else if (stub_pend) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        enc_c     = enc_message ^ {16{8'ha5}};
        enc_done  = 1'b1;
        stub_pend = 1'b0;
      end
    end
  end

  typedef struct {
    logic [127:0] n;
    logic [127:0] msg;
    logic         exp_rng;
    logic         exp_tmo;
    logic         stale;
    int           pat;
    logic [127:0] exp_out;
  } vec_t;

  vec_t vt[7];

  int total = 0;
  int bad   = 0;

  // Observations gathered by collect().
  logic [127:0] got_word;
  logic [127:0] msg_at_start;
  int nb, rng, tmo, starts, first_vi, start_i, tmo_i, stall_bad, inr_bad;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      ok       = in_ready;
    end
    if (!ok) chki("in_ready_bound", 0, 1);
  endtask

  task automatic send_block(input logic [127:0] m);
    for (int j = 0; j < 16; j++) send_byte(m[127-8*j -: 8]);
  endtask

  // Watch the DUT cycle by cycle after the last input byte. pat=1 applies the
  // out_ready sequence 1,0,0,1 during EMIT. Stops after stop_bytes outputs, an
  // error pulse, or stop_wait cycles past enc_start (when stop_wait >= 0).
  task automatic collect(input int pat, input int stop_bytes, input int stop_wait);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       ord;
    logic       fin;
    int         k;
    got_word = '0; msg_at_start = '0;
    nb = 0; rng = 0; tmo = 0; starts = 0; first_vi = -1; start_i = -1; tmo_i = -1;
    stall_bad = 0; inr_bad = 0;
    prev_stall = 1'b0; prev_data = 8'h00; fin = 1'b0; k = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (enc_start) begin
        starts++;
        if (start_i < 0) start_i = i;
        msg_at_start = enc_message;
      end
      if (range_err) rng++;
      if (timeout_err) begin
        tmo++;
        tmo_i = i;
      end
      ord = 1'b1;
      if (out_valid) begin
        if (first_vi < 0) first_vi = i;
        if (in_ready || !busy) inr_bad++;
        if (prev_stall && out_data !== prev_data) stall_bad++;
        if (pat == 1) ord = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
        if (ord) begin
          got_word = {got_word[119:0], out_data};
          nb++;
        end
        prev_stall = !ord;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      out_ready = ord;
      if (nb == stop_bytes || rng != 0 || tmo != 0 ||
          (stop_wait >= 0 && start_i >= 0 && i == start_i + stop_wait)) fin = 1'b1;
    end
    if (!fin) chki("collect_bound", 0, 1);
  endtask

  task automatic run_vec(input int k);
    n          = vt[k].n;
    stub_stale = vt[k].stale;
    send_block(vt[k].msg);
    collect(vt[k].pat, 16, -1);
    if (vt[k].exp_rng) begin
      chki($sformatf("v%0d_range_pulses", k), rng, 1);
      chki($sformatf("v%0d_no_start", k), starts, 0);
      chki($sformatf("v%0d_no_output", k), nb, 0);
    end else if (vt[k].exp_tmo) begin
      chki($sformatf("v%0d_tmo_pulses", k), tmo, 1);
      chki($sformatf("v%0d_start_once", k), starts, 1);
      chki($sformatf("v%0d_tmo_delay", k), tmo_i - start_i, 20);
      chki($sformatf("v%0d_no_output", k), nb, 0);
      chki($sformatf("v%0d_no_range", k), rng, 0);
    end else begin
      chki($sformatf("v%0d_start_once", k), starts, 1);
      chki($sformatf("v%0d_no_range", k), rng, 0);
      chki($sformatf("v%0d_no_tmo", k), tmo, 0);
      chk ($sformatf("v%0d_enc_message", k), msg_at_start, vt[k].msg);
      chk ($sformatf("v%0d_out_block", k), got_word, vt[k].exp_out);
      chki($sformatf("v%0d_latency", k), first_vi + 1, 13);
      chki($sformatf("v%0d_stall_hold", k), stall_bad, 0);
      chki($sformatf("v%0d_in_ready_emit", k), inr_bad, 0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_in_ready_after", k), 128'(in_ready), 128'd1);
    chk($sformatf("v%0d_busy_after", k), 128'(busy), 128'd0);
    chk($sformatf("v%0d_out_valid_after", k), 128'(out_valid), 128'd0);
    stub_stale = 1'b0;
  endtask

  localparam logic [127:0] NMOD = 128'hdfe37dc2fbfce3ac2042306c3a706fb1;

  initial begin
    vt[0] = '{NMOD, {8'h50, 120'd0}, 1'b0, 1'b0, 1'b0, 0, {8'hf5, {15{8'ha5}}}};
    vt[1] = '{NMOD, {128{1'b1}}, 1'b1, 1'b0, 1'b0, 0, 128'd0};
    vt[2] = '{NMOD, NMOD, 1'b1, 1'b0, 1'b0, 0, 128'd0};
    vt[3] = '{128'd0, 128'd0, 1'b1, 1'b0, 1'b0, 0, 128'd0};
    vt[4] = '{NMOD, 128'hdfe37dc2fbfce3ac2042306c3a706fb0, 1'b0, 1'b0, 1'b0, 1,
              128'h7a46d8675e59460985e795c99fd5ca15};
    vt[5] = '{{128{1'b1}}, 128'h0123456789abcdef0011223344556677, 1'b0, 1'b0, 1'b0, 1,
              128'ha486e0c22c0e684aa5b48796e1f0c3d2};
    vt[6] = '{NMOD, {8'h50, 120'd0}, 1'b0, 1'b1, 1'b1, 0, 128'd0};

    // Reset held with a byte offered: nothing may be counted.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'haa;
    out_ready = 1'b0;
    n         = NMOD;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",    128'(in_ready),    128'd1);
    chk("rst_out_valid",   128'(out_valid),   128'd0);
    chk("rst_enc_start",   128'(enc_start),   128'd0);
    chk("rst_busy",        128'(busy),        128'd0);
    chk("rst_out_data",    128'(out_data),    128'd0);
    chk("rst_enc_message", enc_message,       128'd0);
    chk("rst_range_err",   128'(range_err),   128'd0);
    chk("rst_timeout_err", 128'(timeout_err), 128'd0);
    in_valid = 1'b0;
    reset    = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Reset while waiting on the engine.
    n = NMOD;
    send_block(vt[0].msg);
    collect(0, 16, 3);
    chk("mw_busy_before", 128'(busy), 128'd1);
    #2 reset = 1'b0;
    #1;
    chk("mw_busy",        128'(busy),        128'd0);
    chk("mw_in_ready",    128'(in_ready),    128'd1);
    chk("mw_enc_message", enc_message,       128'd0);
    chk("mw_out_valid",   128'(out_valid),   128'd0);
    chk("mw_timeout_err", 128'(timeout_err), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_vec(0);

    // Reset after seven output bytes have been delivered.
    n = NMOD;
    send_block(vt[0].msg);
    collect(0, 7, -1);
    chki("me_bytes_before", nb, 7);
    chk("me_partial", got_word, {72'd0, 8'hf5, {6{8'ha5}}});
    @(negedge clk);
    chk("me_eighth_byte", 128'(out_data), 128'ha5);
    out_ready = 1'b0;
    reset     = 1'b0;
    #1;
    chk("me_out_valid", 128'(out_valid), 128'd0);
    chk("me_out_data",  128'(out_data),  128'd0);
    chk("me_busy",      128'(busy),      128'd0);
    chk("me_in_ready",  128'(in_ready),  128'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_vec(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
